// File: rtl/physical_register_freelist_if.sv
// Rename/commit side <-> freelist bus. The master (rename and retire logic)
// drives requests, commits and pipeline control; the slave (freelist) returns
// grants, the stall flag and the free count.
// Optional feature macro: MIST1032SA_FREELIST_STALL_COUNTER_EN adds oSTAT_STALL_CYCLES.
interface physical_register_freelist_if;
   logic        iLOCK;
   logic        iRESTART_VALID;
   logic        iALLOC_0_REQ;
   logic        iALLOC_1_REQ;
   logic [5:0]  oALLOC_0_REGNAME;
   logic [5:0]  oALLOC_1_REGNAME;
   logic        oALLOC_STALL;
   logic        iCOMMIT_0_VALID;
   logic        iCOMMIT_1_VALID;
   logic [5:0]  iCOMMIT_0_OLD_REGNAME;
   logic [5:0]  iCOMMIT_1_OLD_REGNAME;
   logic [5:0]  oFREE_COUNT;
`ifdef MIST1032SA_FREELIST_STALL_COUNTER_EN
   logic [31:0] oSTAT_STALL_CYCLES;
`endif

   modport master (
      output iLOCK, iRESTART_VALID, iALLOC_0_REQ, iALLOC_1_REQ,
      output iCOMMIT_0_VALID, iCOMMIT_1_VALID, iCOMMIT_0_OLD_REGNAME, iCOMMIT_1_OLD_REGNAME,
      input  oALLOC_0_REGNAME, oALLOC_1_REGNAME, oALLOC_STALL, oFREE_COUNT
`ifdef MIST1032SA_FREELIST_STALL_COUNTER_EN
      , input oSTAT_STALL_CYCLES
`endif
   );

   modport slave (
      input  iLOCK, iRESTART_VALID, iALLOC_0_REQ, iALLOC_1_REQ,
      input  iCOMMIT_0_VALID, iCOMMIT_1_VALID, iCOMMIT_0_OLD_REGNAME, iCOMMIT_1_OLD_REGNAME,
      output oALLOC_0_REGNAME, oALLOC_1_REGNAME, oALLOC_STALL, oFREE_COUNT
`ifdef MIST1032SA_FREELIST_STALL_COUNTER_EN
      , output oSTAT_STALL_CYCLES
`endif
   );
endinterface

// File: rtl/physical_register_freelist.sv
// Physical register freelist: 32-entry circular buffer of free 6-bit regnames.
// SPEC_HEAD..TAIL holds speculatively free names, COMMIT_HEAD..SPEC_HEAD the
// names handed out but not yet retired. Restart rewinds SPEC_HEAD to the
// committed point. Up to two allocations and two commits per cycle.
// Optional feature macro: MIST1032SA_FREELIST_STALL_COUNTER_EN (stall cycle counter).
module physical_register_freelist (
   input logic                         iCLOCK,
   input logic                         iRESET_SYNC,
   physical_register_freelist_if.slave fl
);
   logic [31:0][5:0] b_buf;
   logic [5:0]       b_tail;
   logic [5:0]       b_spec_head;
   logic [5:0]       b_commit_head;

   logic [5:0] free_count;
   logic       stall;
   logic [4:0] spec_head_p1_idx;
   logic [4:0] tail_slot1_idx;
   logic       alloc_fire;
   logic [5:0] alloc_num;
   logic [5:0] commit_num;

   assign free_count       = b_tail - b_spec_head;
   assign stall            = (free_count < 6'd2);
   assign spec_head_p1_idx = b_spec_head[4:0] + 5'd1;
   // Slot 1 lands right behind slot 0 only when slot 0 actually commits.
   assign tail_slot1_idx   = b_tail[4:0] + {4'd0, fl.iCOMMIT_0_VALID};
   assign alloc_fire       = !fl.iLOCK && !stall && !fl.iRESTART_VALID;
   assign alloc_num        = {5'd0, fl.iALLOC_0_REQ} + {5'd0, fl.iALLOC_1_REQ};
   assign commit_num       = {5'd0, fl.iCOMMIT_0_VALID} + {5'd0, fl.iCOMMIT_1_VALID};

   assign fl.oFREE_COUNT      = free_count;
   assign fl.oALLOC_STALL     = stall;
   assign fl.oALLOC_0_REGNAME = b_buf[b_spec_head[4:0]];
   assign fl.oALLOC_1_REGNAME = fl.iALLOC_0_REQ ? b_buf[spec_head_p1_idx] : b_buf[b_spec_head[4:0]];

   // Buffer writes and pointer updates; commits always apply, restart wins over allocation.
   always_ff @(posedge iCLOCK) begin
      if (iRESET_SYNC) begin
         for (int i = 0; i < 32; i++) b_buf[i] <= 6'(32 + i);
         b_tail        <= 6'b100000;
         b_spec_head   <= '0;
         b_commit_head <= '0;
      end else begin
         if (fl.iCOMMIT_0_VALID) b_buf[b_tail[4:0]] <= fl.iCOMMIT_0_OLD_REGNAME;
         if (fl.iCOMMIT_1_VALID) b_buf[tail_slot1_idx] <= fl.iCOMMIT_1_OLD_REGNAME;
         b_tail        <= b_tail + commit_num;
         b_commit_head <= b_commit_head + commit_num;
         if (fl.iRESTART_VALID) b_spec_head <= b_commit_head + commit_num;
         else if (alloc_fire)   b_spec_head <= b_spec_head + alloc_num;
      end
   end

`ifdef MIST1032SA_FREELIST_STALL_COUNTER_EN
   logic [31:0] b_stall_cycles;
   assign fl.oSTAT_STALL_CYCLES = b_stall_cycles;

   // Count cycles where a request is turned away by the stall, saturating.
   always_ff @(posedge iCLOCK) begin
      if (iRESET_SYNC) b_stall_cycles <= '0;
      else if ((fl.iALLOC_0_REQ || fl.iALLOC_1_REQ) && stall && (b_stall_cycles != 32'hFFFF_FFFF))
         b_stall_cycles <= b_stall_cycles + 32'd1;
   end
`endif
endmodule

// File: tb/tb_physical_register_freelist.sv
// Directed checks of the freelist with hand-computed values, followed by a
// randomized run against a queue-based model of free / speculative / architectural names.
module tb_physical_register_freelist;
   logic iCLOCK = 1'b0;
   logic iRESET_SYNC = 1'b1;
   always #5 iCLOCK = ~iCLOCK;

   physical_register_freelist_if fl();
   physical_register_freelist dut (.iCLOCK(iCLOCK), .iRESET_SYNC(iRESET_SYNC), .fl(fl));

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic tick;
      @(posedge iCLOCK);
      #1;
   endtask

   task automatic drv(input logic lock, input logic rs, input logic r0, input logic r1,
                      input logic c0, input logic [5:0] o0, input logic c1, input logic [5:0] o1);
      fl.iLOCK = lock;
      fl.iRESTART_VALID = rs;
      fl.iALLOC_0_REQ = r0;
      fl.iALLOC_1_REQ = r1;
      fl.iCOMMIT_0_VALID = c0;
      fl.iCOMMIT_0_OLD_REGNAME = o0;
      fl.iCOMMIT_1_VALID = c1;
      fl.iCOMMIT_1_OLD_REGNAME = o1;
      #1;
   endtask

   // model state
   int freeq[$];
   int specq[$];
   int arch[$];
   int scnt;

   initial begin
      drv(0, 0, 0, 0, 0, 0, 0, 0);
      tick; tick;
      iRESET_SYNC = 1'b0;
      #1;
      // reset state
      chk("rst_count", 32'(fl.oFREE_COUNT), 32);
      chk("rst_stall", 32'(fl.oALLOC_STALL), 0);
      chk("rst_a0", 32'(fl.oALLOC_0_REGNAME), 32);
      chk("rst_a1_noreq0", 32'(fl.oALLOC_1_REGNAME), 32);
      drv(0, 0, 1, 0, 0, 0, 0, 0);
      chk("rst_a1_req0", 32'(fl.oALLOC_1_REGNAME), 33);

      // two dual allocs
      drv(0, 0, 1, 1, 0, 0, 0, 0);
      chk("dual1_a0", 32'(fl.oALLOC_0_REGNAME), 32);
      chk("dual1_a1", 32'(fl.oALLOC_1_REGNAME), 33);
      tick;
      chk("dual2_a0", 32'(fl.oALLOC_0_REGNAME), 34);
      chk("dual2_a1", 32'(fl.oALLOC_1_REGNAME), 35);
      tick;
      chk("dual2_count", 32'(fl.oFREE_COUNT), 28);

      // drain to 2, then 0
      for (int k = 0; k < 13; k++) tick;
      chk("drain_count2", 32'(fl.oFREE_COUNT), 2);
      chk("drain_stall0", 32'(fl.oALLOC_STALL), 0);
      chk("drain_a0", 32'(fl.oALLOC_0_REGNAME), 62);
      chk("drain_a1", 32'(fl.oALLOC_1_REGNAME), 63);
      tick;
      chk("empty_count", 32'(fl.oFREE_COUNT), 0);
      chk("empty_stall", 32'(fl.oALLOC_STALL), 1);
      chk("empty_a0", 32'(fl.oALLOC_0_REGNAME), 32);
      tick;
      chk("ignored_count", 32'(fl.oFREE_COUNT), 0);
      chk("ignored_stall", 32'(fl.oALLOC_STALL), 1);
      chk("ignored_a0", 32'(fl.oALLOC_0_REGNAME), 32);
      chk("ignored_a1", 32'(fl.oALLOC_1_REGNAME), 33);

      // commit 5,9 while empty: no grant this cycle, granted next
      drv(0, 0, 1, 1, 1, 6'd5, 1, 6'd9);
      chk("cmt_same_stall", 32'(fl.oALLOC_STALL), 1);
      tick;
      drv(0, 0, 1, 1, 0, 0, 0, 0);
      chk("cmt_next_count", 32'(fl.oFREE_COUNT), 2);
      chk("cmt_next_a0", 32'(fl.oALLOC_0_REGNAME), 5);
      chk("cmt_next_a1", 32'(fl.oALLOC_1_REGNAME), 9);
      tick;
      chk("cmt_after_count", 32'(fl.oFREE_COUNT), 0);

      // reset mid-operation overrides everything
      drv(0, 1, 1, 1, 1, 6'd3, 1, 6'd4);
      iRESET_SYNC = 1'b1;
      tick;
      iRESET_SYNC = 1'b0;
      drv(0, 0, 0, 0, 0, 0, 0, 0);
      chk("midrst_count", 32'(fl.oFREE_COUNT), 32);
      chk("midrst_a0", 32'(fl.oALLOC_0_REGNAME), 32);

      // 6 allocs, 2 commits, restart
      drv(0, 0, 1, 1, 0, 0, 0, 0);
      tick; tick; tick;
      drv(0, 0, 0, 0, 1, 6'd1, 1, 6'd2);
      tick;
      drv(0, 0, 0, 0, 0, 0, 0, 0);
      chk("pre_rs_count", 32'(fl.oFREE_COUNT), 28);
      drv(0, 1, 1, 1, 0, 0, 0, 0);
      tick;
      drv(0, 0, 0, 0, 0, 0, 0, 0);
      chk("rs_count", 32'(fl.oFREE_COUNT), 32);
      chk("rs_a0", 32'(fl.oALLOC_0_REGNAME), 34);

      // lock blocks allocation
      drv(1, 0, 1, 1, 0, 0, 0, 0);
      tick;
      chk("lock_count", 32'(fl.oFREE_COUNT), 32);

      // one alloc, then restart with one commit and an alloc request
      drv(0, 0, 1, 0, 0, 0, 0, 0);
      tick;
      chk("single_count", 32'(fl.oFREE_COUNT), 31);
      drv(0, 1, 1, 1, 1, 6'd7, 0, 0);
      tick;
      drv(0, 0, 1, 0, 0, 0, 0, 0);
      chk("rscmt_count", 32'(fl.oFREE_COUNT), 32);
      chk("rscmt_a0", 32'(fl.oALLOC_0_REGNAME), 35);
      chk("rscmt_a1", 32'(fl.oALLOC_1_REGNAME), 36);

      // randomized run against the queue model
      drv(0, 0, 0, 0, 0, 0, 0, 0);
      iRESET_SYNC = 1'b1;
      tick;
      iRESET_SYNC = 1'b0;
      freeq.delete(); specq.delete(); arch.delete();
      for (int i = 0; i < 32; i++) begin
         arch.push_back(i);
         freeq.push_back(32 + i);
      end
      scnt = 0;
      for (int cyc = 0; cyc < 10000; cyc++) begin
         logic lock, rs, r0, r1, c0, c1, fire;
         logic [5:0] o0, o1;
         int nsp, idx, n0, n1;
         lock = ($urandom_range(0, 7) == 0);
         rs   = ($urandom_range(0, 31) == 0);
         r0   = 1'($urandom_range(0, 1));
         r1   = 1'($urandom_range(0, 1));
         nsp  = specq.size();
         c0   = (nsp >= 1) && ($urandom_range(0, 1) == 1);
         c1   = (nsp >= (c0 ? 2 : 1)) && ($urandom_range(0, 1) == 1);
         o0 = 0; o1 = 0;
         if (c0) begin
            idx = $urandom_range(0, arch.size() - 1);
            o0 = 6'(arch[idx]); arch.delete(idx);
         end
         if (c1) begin
            idx = $urandom_range(0, arch.size() - 1);
            o1 = 6'(arch[idx]); arch.delete(idx);
         end
         drv(lock, rs, r0, r1, c0, o0, c1, o1);
         chk("rnd_count", 32'(fl.oFREE_COUNT), 32'(freeq.size()));
         chk("rnd_stall", 32'(fl.oALLOC_STALL), 32'(freeq.size() < 2));
         if (freeq.size() > 0) chk("rnd_a0", 32'(fl.oALLOC_0_REGNAME), 32'(freeq[0]));
         if (r0 && freeq.size() > 1) chk("rnd_a1", 32'(fl.oALLOC_1_REGNAME), 32'(freeq[1]));
         if (!r0 && freeq.size() > 0) chk("rnd_a1s", 32'(fl.oALLOC_1_REGNAME), 32'(freeq[0]));
`ifdef MIST1032SA_FREELIST_STALL_COUNTER_EN
         chk("rnd_stallcnt", fl.oSTAT_STALL_CYCLES, 32'(scnt));
         if ((r0 || r1) && freeq.size() < 2) scnt++;
`endif
         fire = !lock && !rs && (freeq.size() >= 2);
         if (fire && r0) begin n0 = freeq.pop_front(); specq.push_back(n0); end
         if (fire && r1) begin n1 = freeq.pop_front(); specq.push_back(n1); end
         if (c0) begin arch.push_back(specq.pop_front()); freeq.push_back(int'(o0)); end
         if (c1) begin arch.push_back(specq.pop_front()); freeq.push_back(int'(o1)); end
         if (rs) begin
            freeq = {specq, freeq};
            specq.delete();
         end
         tick;
      end
      drv(0, 0, 0, 0, 0, 0, 0, 0);
      chk("rnd_final_count", 32'(fl.oFREE_COUNT), 32'(freeq.size()));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
